// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline register for a CPU stage boundary.
// Holds a packed payload plus PC in a main entry and an optional skid entry,
// supports synchronous flush, bubble clearing and a saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned           DATA_W       = 128,
  parameter int unsigned           PC_W         = 32,
  parameter logic [PC_W-1:0]       RESET_PC     = 32'h1bfffffc,
  parameter bit                    SKID         = 1'b1,
  parameter bit                    CLEAR_BUBBLE = 1'b1,
  parameter int unsigned           CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKIDF = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  main_data_q, main_data_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic               in_fire;
  logic               out_fire;

  // Output view: always the main entry; allowin is registered with a skid entry.
  always_comb begin
    out_valid = (state_q != EMPTY);
    out_data  = main_data_q;
    out_pc    = main_pc_q;
    stall_cnt = stall_q;
    in_ready  = SKID ? in_ready_q : (!out_valid || out_ready);
    unique case (state_q)
      FULL:    occupancy = 2'd1;
      SKIDF:   occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next-state logic for the entries, handshake and stall counter.
  always_comb begin
    in_fire     = in_valid && in_ready && !flush;
    out_fire    = out_valid && out_ready;
    state_d     = state_q;
    main_data_d = main_data_q;
    main_pc_d   = main_pc_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    stall_d     = stall_q;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d     = FULL;
          main_data_d = in_data;
          main_pc_d   = in_pc;
        end
      end
      FULL: begin
        if (in_fire && out_fire) begin
          main_data_d = in_data;
          main_pc_d   = in_pc;
        end else if (in_fire && SKID) begin
          state_d     = SKIDF;
          skid_data_d = in_data;
          skid_pc_d   = in_pc;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      SKIDF: begin
        if (out_fire) begin
          state_d     = FULL;
          main_data_d = skid_data_q;
          main_pc_d   = skid_pc_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (flush) begin
      state_d = EMPTY;
    end

    // Bubble: an empty stage presents a zero payload and the reset PC.
    if (CLEAR_BUBBLE && (state_d == EMPTY)) begin
      main_data_d = '0;
      main_pc_d   = RESET_PC;
    end

    in_ready_d = (state_d != SKIDF);

    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_pc_q   <= RESET_PC;
      skid_data_q <= '0;
      skid_pc_q   <= RESET_PC;
      in_ready_q  <= 1'b1;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_pc_q   <= main_pc_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
      in_ready_q  <= in_ready_d;
      stall_q     <= stall_d;
    end
  end

endmodule
